// File: rtl/usb_bus_arb_pkg.sv
// Shared constants for the two-master USB core bus arbiter: bus widths,
// watchdog counter width and the arbiter state encoding.
package usb_bus_arb_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT0  = 2'd1,
    ST_GRANT1  = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/usb_bus_arb.sv
// Two-master arbiter in front of the USB core bus (round-robin or fixed priority).
// Optional slave-ack watchdog is compiled in with macro USB_BUS_ARB_TIMEOUT_EN.
module usb_bus_arb
  import usb_bus_arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_we,
  input  logic              m0_cyc,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_we,
  input  logic              m1_cyc,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_we,
  output logic              s_cyc,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ack
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_e state_q;
  logic   last_q;       // 1 = master 1 held the bus most recently
  logic   in_grant;
  logic   own_cyc;
  logic   grant_done;
  logic   pick1;
  logic   tmo_hit;

`ifdef USB_BUS_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  logic [CNT_W-1:0] wd_cnt_q;

  assign tmo_hit = in_grant && own_cyc && !s_ack && (wd_cnt_q == TMO_LAST);
`else
  logic unused_tmo_cfg;

  assign unused_tmo_cfg = ^TMO_LAST;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    in_grant   = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);
    own_cyc    = (state_q == ST_GRANT1) ? m1_cyc : m0_cyc;
    grant_done = in_grant && (s_ack || !own_cyc || tmo_hit);
    // On contention master 1 wins only in round-robin mode after master 0 had the bus.
    pick1      = m1_cyc && (!m0_cyc || ((ROUND_ROBIN != 0) && !last_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
`ifdef USB_BUS_ARB_TIMEOUT_EN
      wd_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m0_cyc || m1_cyc) begin
            state_q <= pick1 ? ST_GRANT1 : ST_GRANT0;
            last_q  <= pick1;
          end
        end
        ST_GRANT0, ST_GRANT1: begin
          if (grant_done) state_q <= ST_RELEASE;
        end
        default: state_q <= ST_IDLE;
      endcase
`ifdef USB_BUS_ARB_TIMEOUT_EN
      if (state_q == ST_IDLE) begin
        wd_cnt_q <= '0;
      end else if (in_grant && !s_ack) begin
        wd_cnt_q <= wd_cnt_q + CNT_ONE;
      end
`endif
    end
  end

  // Bus path is a pure decode of the registered state so reset clears it at once.
  always_comb begin
    s_cyc    = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_we     = 1'b0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_rdata = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_rdata = '0;
    case (state_q)
      ST_GRANT0: begin
        s_cyc    = m0_cyc && !tmo_hit;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_we     = m0_we;
        m0_ack   = m0_cyc && (s_ack || tmo_hit);
        m0_err   = tmo_hit;
        m0_rdata = (m0_cyc && s_ack) ? s_rdata : '0;
      end
      ST_GRANT1: begin
        s_cyc    = m1_cyc && !tmo_hit;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_we     = m1_we;
        m1_ack   = m1_cyc && (s_ack || tmo_hit);
        m1_err   = tmo_hit;
        m1_rdata = (m1_cyc && s_ack) ? s_rdata : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_usb_bus_arb.sv
// Bench for usb_bus_arb: a round-robin and a fixed-priority instance share stimulus
// and are compared against a transaction-level bus ownership model.
module tb_usb_bus_arb;

`ifdef USB_BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TMO = 8;

  logic        clk;
  logic        rst;
  logic [11:0] m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata, s_rdata;
  logic        m0_we, m1_we, m0_cyc, m1_cyc, s_ack;

  logic [11:0] a_s_addr, b_s_addr;
  logic [15:0] a_s_wdata, b_s_wdata, a_m0_rdata, a_m1_rdata, b_m0_rdata, b_m1_rdata;
  logic        a_s_we, a_s_cyc, a_m0_ack, a_m0_err, a_m1_ack, a_m1_err;
  logic        b_s_we, b_s_cyc, b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;

  usb_bus_arb #(.ROUND_ROBIN(1), .TIMEOUT(TMO)) dut_rr (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_cyc(m0_cyc),
    .m0_rdata(a_m0_rdata), .m0_ack(a_m0_ack), .m0_err(a_m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_cyc(m1_cyc),
    .m1_rdata(a_m1_rdata), .m1_ack(a_m1_ack), .m1_err(a_m1_err),
    .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_we(a_s_we), .s_cyc(a_s_cyc),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  usb_bus_arb #(.ROUND_ROBIN(0), .TIMEOUT(TMO)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_cyc(m0_cyc),
    .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack), .m0_err(b_m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_cyc(m1_cyc),
    .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack), .m1_err(b_m1_err),
    .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_we(b_s_we), .s_cyc(b_s_cyc),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  logic [65:0] a_out, b_out;
  assign a_out = {a_s_cyc, a_s_we, a_s_addr, a_s_wdata, a_m0_ack, a_m0_err, a_m0_rdata,
                  a_m1_ack, a_m1_err, a_m1_rdata};
  assign b_out = {b_s_cyc, b_s_we, b_s_addr, b_s_wdata, b_m0_ack, b_m0_err, b_m0_rdata,
                  b_m1_ack, b_m1_err, b_m1_rdata};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: which master owns the bus, whether the mandatory idle gap
  // is pending, who wins the next contention, and how long the owner has waited.
  int owner[2];
  bit gap[2];
  int pref[2];
  int waited[2];

  function automatic void model_reset_one(int i);
    owner[i]  = -1;
    gap[i]    = 1'b0;
    pref[i]   = 0;
    waited[i] = 0;
  endfunction

  function automatic bit owner_cyc(int i);
    return (owner[i] == 0) ? m0_cyc : m1_cyc;
  endfunction

  function automatic bit timed_out(int i);
    return TO_EN && owner_cyc(i) && !s_ack && (waited[i] == TMO - 1);
  endfunction

  function automatic logic [65:0] model_out(int i);
    logic        scyc, swe, a0, e0, a1, e1, mc, to;
    logic [11:0] sa;
    logic [15:0] swd, r0, r1;
    scyc = 0; swe = 0; a0 = 0; e0 = 0; a1 = 0; e1 = 0;
    sa = '0; swd = '0; r0 = '0; r1 = '0;
    if (owner[i] >= 0) begin
      mc   = owner_cyc(i);
      to   = timed_out(i);
      scyc = mc && !to;
      sa   = (owner[i] == 0) ? m0_addr : m1_addr;
      swd  = (owner[i] == 0) ? m0_wdata : m1_wdata;
      swe  = (owner[i] == 0) ? m0_we : m1_we;
      if (owner[i] == 0) begin
        a0 = mc && (s_ack || to);
        e0 = to;
        r0 = (mc && s_ack) ? s_rdata : 16'h0;
      end else begin
        a1 = mc && (s_ack || to);
        e1 = to;
        r1 = (mc && s_ack) ? s_rdata : 16'h0;
      end
    end
    return {scyc, swe, sa, swd, a0, e0, r0, a1, e1, r1};
  endfunction

  function automatic void model_step(int i);
    int w;
    if (owner[i] >= 0) begin
      if (!owner_cyc(i) || s_ack || timed_out(i)) begin
        owner[i] = -1;
        gap[i]   = 1'b1;
      end else begin
        waited[i]++;
      end
    end else if (gap[i]) begin
      gap[i] = 1'b0;
    end else if (m0_cyc || m1_cyc) begin
      if (m0_cyc && m1_cyc) w = (i == 0) ? pref[i] : 0;
      else w = m0_cyc ? 0 : 1;
      owner[i]  = w;
      waited[i] = 0;
      pref[i]   = 1 - w;
    end
  endfunction

  task automatic check_now();
    chk("model_rr", a_out, model_out(0));
    chk("model_fp", b_out, model_out(1));
  endtask

  task automatic advance();
    for (int i = 0; i < 2; i++) begin
      if (rst) model_reset_one(i);
      else model_step(i);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    check_now();
    advance();
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_cyc = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    s_ack = 0; s_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 2; i++) model_reset_one(i);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rr", a_out, '0);
    chk("reset_fp", b_out, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic m0c; logic m0w; logic [11:0] m0a; logic [15:0] m0d;
    logic m1c; logic m1w; logic [11:0] m1a; logic [15:0] m1d;
    logic sack; logic [15:0] srd;
    logic e_scyc; logic e_swe; logic [11:0] e_sa; logic [15:0] e_swd;
    logic e_a0; logic [15:0] e_r0; logic e_a1; logic [15:0] e_r1;
  } vec_t;

  vec_t vecs[16];
  int   qa[$];
  int   qb[$];

  initial begin
    int          ack_at, err_seen;
    logic        sc9;
    logic [65:0] exp_v;

    // single write, EPS read with s_ack ignored afterwards, then an abort
    vecs[0]  = '{1,1,12'h000,16'h8000, 0,0,12'h000,16'h0000, 0,16'h0000, 0,0,12'h000,16'h0000, 0,16'h0000,0,16'h0000};
    vecs[1]  = '{1,1,12'h000,16'h8000, 0,0,12'h000,16'h0000, 1,16'h0000, 1,1,12'h000,16'h8000, 1,16'h0000,0,16'h0000};
    vecs[2]  = '{0,0,12'h000,16'h0000, 0,0,12'h000,16'h0000, 0,16'h0000, 0,0,12'h000,16'h0000, 0,16'h0000,0,16'h0000};
    vecs[3]  = vecs[2];
    vecs[4]  = '{0,0,12'h000,16'h0000, 1,0,12'h800,16'h0000, 0,16'h1234, 0,0,12'h000,16'h0000, 0,16'h0000,0,16'h0000};
    vecs[5]  = '{0,0,12'h000,16'h0000, 1,0,12'h800,16'h0000, 0,16'h1234, 1,0,12'h800,16'h0000, 0,16'h0000,0,16'h0000};
    vecs[6]  = vecs[5];
    vecs[7]  = vecs[5];
    vecs[8]  = '{0,0,12'h000,16'h0000, 1,0,12'h800,16'h0000, 1,16'h1234, 1,0,12'h800,16'h0000, 0,16'h0000,1,16'h1234};
    vecs[9]  = '{0,0,12'h000,16'h0000, 0,0,12'h000,16'h0000, 1,16'hFFFF, 0,0,12'h000,16'h0000, 0,16'h0000,0,16'h0000};
    vecs[10] = vecs[9];
    vecs[11] = '{1,0,12'h123,16'h5A5A, 0,0,12'h000,16'h0000, 0,16'h0000, 0,0,12'h000,16'h0000, 0,16'h0000,0,16'h0000};
    vecs[12] = '{1,0,12'h123,16'h5A5A, 0,0,12'h000,16'h0000, 0,16'h0000, 1,0,12'h123,16'h5A5A, 0,16'h0000,0,16'h0000};
    vecs[13] = '{0,0,12'h123,16'h5A5A, 0,0,12'h000,16'h0000, 0,16'h0000, 0,0,12'h123,16'h5A5A, 0,16'h0000,0,16'h0000};
    vecs[14] = vecs[2];
    vecs[15] = vecs[2];

    do_reset();

    for (int r = 0; r < 16; r++) begin
      m0_cyc = vecs[r].m0c; m0_we = vecs[r].m0w; m0_addr = vecs[r].m0a; m0_wdata = vecs[r].m0d;
      m1_cyc = vecs[r].m1c; m1_we = vecs[r].m1w; m1_addr = vecs[r].m1a; m1_wdata = vecs[r].m1d;
      s_ack = vecs[r].sack; s_rdata = vecs[r].srd;
      exp_v = {vecs[r].e_scyc, vecs[r].e_swe, vecs[r].e_sa, vecs[r].e_swd,
               vecs[r].e_a0, 1'b0, vecs[r].e_r0, vecs[r].e_a1, 1'b0, vecs[r].e_r1};
      @(negedge clk);
      check_now();
      chk($sformatf("vec%0d_rr", r), a_out, exp_v);
      chk($sformatf("vec%0d_fp", r), b_out, exp_v);
      advance();
    end

    // contention: both masters hold cyc, core acks immediately
    do_reset();
    m0_cyc = 1; m0_addr = 12'h0A0; m0_wdata = 16'h1111; m0_we = 1;
    m1_cyc = 1; m1_addr = 12'h0B0; m1_wdata = 16'h2222; m1_we = 0;
    s_ack = 1; s_rdata = 16'h4321;
    for (int k = 0; k < 40 && (qa.size() < 6 || qb.size() < 6); k++) begin
      @(negedge clk);
      check_now();
      if (a_m0_ack) qa.push_back(0);
      if (a_m1_ack) qa.push_back(1);
      if (b_m0_ack) qb.push_back(0);
      if (b_m1_ack) qb.push_back(1);
      advance();
    end
    chk("rr_grant_count", 66'(qa.size() >= 6), 66'd1);
    chk("fp_grant_count", 66'(qb.size() >= 6), 66'd1);
    for (int k = 0; k < 6 && k < qa.size(); k++) chk($sformatf("rr_order%0d", k), 66'(qa[k]), 66'(k % 2));
    for (int k = 0; k < 6 && k < qb.size(); k++) chk($sformatf("fp_order%0d", k), 66'(qb[k]), 66'd0);

    // watchdog: core never acks
    idle_inputs();
    repeat (3) tick();
    m0_cyc = 1; m0_addr = 12'h321; m0_wdata = 16'hCAFE; m0_we = 1;
    tick();
    ack_at = 0; err_seen = 0; sc9 = 1'bx;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check_now();
      if (a_m0_ack && ack_at == 0) begin
        ack_at   = k;
        err_seen = int'(a_m0_err);
      end
      if (k == 9) sc9 = a_s_cyc;
      advance();
    end
    chk("timeout_ack_cycle", 66'(ack_at), TO_EN ? 66'd8 : 66'd0);
    chk("timeout_err", 66'(err_seen), TO_EN ? 66'd1 : 66'd0);
    chk("timeout_scyc_after", 66'(sc9), TO_EN ? 66'd0 : 66'd1);
    idle_inputs();
    repeat (3) tick();

    // reset in the middle of a GRANT1 transaction
    m1_cyc = 1; m1_addr = 12'h7FF; m1_wdata = 16'hBEEF; m1_we = 1;
    tick();
    tick();
    chk("pre_rst_scyc", 66'(a_s_cyc), 66'd1);
    #1;
    s_ack = 1; s_rdata = 16'h9999;
    rst = 1'b1;
    #1;
    chk("rst_mid_rr", a_out, '0);
    chk("rst_mid_fp", b_out, '0);
    for (int i = 0; i < 2; i++) model_reset_one(i);
    tick();
    rst = 1'b0;
    m0_cyc = 1; m0_addr = 12'h055; m0_wdata = 16'h0F0F; m0_we = 0;
    tick();
    @(negedge clk);
    check_now();
    chk("rst_first_grant_m0", {64'd0, a_m0_ack, a_m1_ack}, 66'b10);
    advance();

    // randomized traffic
    idle_inputs();
    repeat (3) tick();
    for (int c = 0; c < 2000; c++) begin
      m0_cyc   = m0_cyc ? ($urandom_range(99, 0) < 90) : ($urandom_range(99, 0) < 30);
      m1_cyc   = m1_cyc ? ($urandom_range(99, 0) < 90) : ($urandom_range(99, 0) < 30);
      m0_addr  = 12'($urandom); m1_addr  = 12'($urandom);
      m0_wdata = 16'($urandom); m1_wdata = 16'($urandom);
      m0_we    = 1'($urandom);  m1_we    = 1'($urandom);
      s_ack    = ($urandom_range(99, 0) < 30);
      s_rdata  = 16'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/usb_bus_arb.md
USB_BUS_ARB -- requirements
Module: usb_bus_arb

Interface
REQ-001 SHALL have parameter ROUND_ROBIN, default 1; 1 = round-robin between masters, 0 = fixed priority with master 0 winning.
REQ-002 SHALL have parameter TIMEOUT, default 255; slave-ack watchdog limit in clk cycles, range 2..255, used only with the watchdog compiled in.
REQ-003 SHALL have port clk, input, 1, sole clock; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have, for n = 0 and 1, port mn_addr, input, 12, master n bus address.
REQ-006 SHALL have, for n = 0 and 1, port mn_wdata, input, 16, master n write data.
REQ-007 SHALL have, for n = 0 and 1, port mn_we, input, 1, master n write enable.
REQ-008 SHALL have, for n = 0 and 1, port mn_cyc, input, 1, master n cycle request.
REQ-009 SHALL have, for n = 0 and 1, port mn_rdata, output, 16, master n read data; zero when not acked.
REQ-010 SHALL have, for n = 0 and 1, port mn_ack, output, 1, master n one-cycle acknowledge.
REQ-011 SHALL have, for n = 0 and 1, port mn_err, output, 1, master n one-cycle timeout flag.
REQ-012 SHALL have ports s_addr (output, 12), s_wdata (output, 16), s_we (output, 1) and s_cyc (output, 1), forming the request to the USB core bus.
REQ-013 SHALL have ports s_rdata (input, 16) and s_ack (input, 1), forming the response from the USB core bus.

Function
REQ-014 SHALL implement four states, IDLE, GRANT0, GRANT1 and RELEASE, encoded in a registered state variable.
REQ-015 IDLE: s_cyc=0; IDLE SHALL go to GRANTn next cycle when mn_cyc=1 and n wins arbitration, else stay in IDLE.
REQ-016 Arbitration with both masters requesting: with ROUND_ROBIN=1 the master not granted last SHALL win; with ROUND_ROBIN=0 master 0 SHALL win; the last-granted register SHALL update on entry to GRANTn.
REQ-017 Latency: mn_cyc rising in cycle N SHALL give s_cyc=1 in cycle N+1 at the earliest.
REQ-018 GRANTn: s_cyc=mn_cyc and s_addr/s_wdata/s_we=master n's; mn_ack=s_ack and mn_rdata=s_rdata&{16{s_ack}}; the other master SHALL see ack=0, rdata=0 and err=0.
REQ-019 GRANTn SHALL go to RELEASE on s_ack=1 or on mn_cyc=0 (abort); an aborted cycle SHALL produce no ack.
REQ-020 RELEASE: s_cyc=0 for exactly one cycle, then IDLE; this guarantees the core sees cyc low between transactions.
REQ-021 s_addr, s_wdata and s_we SHALL be zero outside GRANT states.
REQ-022 A master still holding cyc after its ack SHALL be treated as a new request and re-arbitrated in IDLE.
REQ-023 s_ack while in IDLE or RELEASE SHALL be ignored.

Reset
REQ-024 On rst, asynchronously: state=IDLE, last-granted=1 (master 0 first), watchdog counter=0.
REQ-025 During and after rst, all outputs SHALL be 0 until the first grant.
REQ-026 Reset mid-transaction SHALL drop s_cyc immediately with no ack to either master.

Configuration
REQ-027 Macro USB_BUS_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on GRANT entry and increment each GRANT cycle without s_ack.
REQ-028 With USB_BUS_ARB_TIMEOUT_EN, when the counter reaches TIMEOUT-1 with no s_ack: mn_ack=1 and mn_err=1 for that cycle, mn_rdata=16'h0000, s_cyc dropped, then RELEASE.
REQ-029 Macro undefined: no counter; mn_err tied 0; GRANT waits indefinitely for s_ack or abort.

Structure
REQ-030 A shared package SHALL hold the state encoding constants and the bus width constants (address 12, data 16).
REQ-031 SHALL contain no sub-module; watchdog inline under the macro.

Verification
REQ-032 Single write: m0 cyc/we, addr 12'h000, data 16'h8000, core acks 1 cycle later -> s_cyc in cycle N+1, m0_ack one cycle, then s_cyc low one cycle.
REQ-033 Contention: m0 and m1 both assert cyc in the same cycle, ROUND_ROBIN=1, 3 back-to-back rounds -> grant order 0,1,0,1,0,1; with ROUND_ROBIN=0 -> m0 every round while it requests.
REQ-034 EPS read: m1 reads addr 12'h800, core acks after 4 cycles with 16'h1234 -> m1_rdata=16'h1234 only during ack; m0_rdata=0 throughout.
REQ-035 Abort: m0 drops cyc in the 2nd GRANT0 cycle -> no m0_ack, RELEASE, then IDLE.
REQ-036 Timeout (macro on, TIMEOUT=8): core never acks -> m0_ack=m0_err=1 in the 8th grant cycle, then s_cyc=0.
REQ-037 Reset mid-GRANT1 -> all outputs 0 same cycle; the first grant after release goes to m0 on contention.
